// File: rtl/reset_sequencer_if.sv
// Control/status bundle for reset_sequencer: restart/lock requests in, reset
// outputs and sequence status out. master = sequencer side, slave = consumer side.
interface reset_sequencer_if #(
    parameter int unsigned NUM_OUT = 2,
    parameter int unsigned CW      = 22
);
    logic               restart;
    logic               lock;
    logic [NUM_OUT-1:0] nrst;
    logic               busy;
    logic               done;
    logic [CW-1:0]      count;

    modport master (
        input  restart, lock,
        output nrst, busy, done, count
    );

    modport slave (
        output restart, lock,
        input  nrst, busy, done, count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on / soft-reset sequencer: NUM_OUT active-low resets released at per-output
// counts after a common start. Optional macro RESET_SEQ_LOCK_EN gates counting on lock.
module reset_sequencer #(
    parameter int unsigned             NUM_OUT = 2,
    parameter int unsigned             CW      = 22,
    parameter logic [NUM_OUT*CW-1:0]   THRESH  = {22'd2000000, 22'd1500000},
    parameter logic [CW-1:0]           TERM    = 22'd4194303
) (
    input logic                clk,
    input logic                reset,
    reset_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        WAIT,
        COUNT,
        DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_inc;
    logic [NUM_OUT-1:0] nrst_q;
    logic [NUM_OUT-1:0] past_thresh;
    logic               done_q;
    logic               busy_q;
    logic               lock_ok;
    logic               force_wait;

`ifdef RESET_SEQ_LOCK_EN
    assign lock_ok = bus.lock;
`else
    assign lock_ok = 1'b1;
`endif

    // Losing lock is handled exactly like a restart: the whole sequence goes back to WAIT.
    assign force_wait = reset | bus.restart | ~lock_ok;
    assign count_inc  = count_q + 1'b1;

    always_comb begin
        past_thresh = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            past_thresh[i] = (count_q > THRESH[i*CW +: CW]);
        end
    end

    always_ff @(posedge clk) begin
        if (force_wait) begin
            state   <= WAIT;
            count_q <= '0;
            nrst_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            nrst_q <= (state == WAIT) ? '0 : past_thresh;
            done_q <= (count_q == TERM);
            busy_q <= (count_q != TERM);
            case (state)
                WAIT, COUNT: begin
                    count_q <= count_inc;
                    state   <= (count_inc == TERM) ? DONE : COUNT;
                end
                DONE: begin
                    count_q <= TERM;
                    state   <= DONE;
                end
                default: begin
                    count_q <= '0;
                    state   <= WAIT;
                end
            endcase
        end
    end

    assign bus.nrst  = nrst_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: three instances (CW=4, TERM=10) with
// thresholds {6,3}, {10,3} and {5,5}, driven by common reset/restart/lock.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic restart;
    logic lock;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_OUT(2), .CW(4)) if_a ();
    reset_sequencer_if #(.NUM_OUT(2), .CW(4)) if_b ();
    reset_sequencer_if #(.NUM_OUT(2), .CW(4)) if_c ();

    assign if_a.restart = restart;
    assign if_a.lock    = lock;
    assign if_b.restart = restart;
    assign if_b.lock    = lock;
    assign if_c.restart = restart;
    assign if_c.lock    = lock;

    reset_sequencer #(.NUM_OUT(2), .CW(4), .THRESH({4'd6, 4'd3}), .TERM(4'd10))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    reset_sequencer #(.NUM_OUT(2), .CW(4), .THRESH({4'd10, 4'd3}), .TERM(4'd10))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    reset_sequencer #(.NUM_OUT(2), .CW(4), .THRESH({4'd5, 4'd5}), .TERM(4'd10))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    typedef struct packed {
        logic [3:0] count;
        logic       done;
        logic       busy;
        logic [1:0] nrst_a;
        logic [1:0] nrst_b;
        logic [1:0] nrst_c;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;
    int   k      = 0;   // edge number since sequence start, 0 while held in WAIT
    int   edge_n = 0;

    // Expected outputs k edges after start, from the documented release timing.
    function automatic exp_t expect_at(input int kk);
        exp_t e;
        e.count  = (kk > 10) ? 4'd10 : 4'(kk);
        e.done   = (kk >= 11);
        e.busy   = !(kk >= 11);
        e.nrst_a = {kk >= 8, kk >= 5};
        e.nrst_b = {1'b0, kk >= 5};
        e.nrst_c = {kk >= 7, kk >= 7};
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s edge %0d: got %0d expected %0d", name, edge_n, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic cyc(input logic rst_v, input logic rs_v, input logic lk_v);
        logic lock_cond;
`ifdef RESET_SEQ_LOCK_EN
        lock_cond = lk_v;
`else
        lock_cond = 1'b1;
`endif
        reset   = rst_v;
        restart = rs_v;
        lock    = lk_v;
        if (rst_v || rs_v || !lock_cond) k = 0;
        else if (k < 15) k++;
        exp_q.push_back(expect_at(k));
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n, input logic rst_v, input logic rs_v, input logic lk_v);
        for (int i = 0; i < n; i++) cyc(rst_v, rs_v, lk_v);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("count_a", int'(if_a.count), int'(e.count));
                check("count_b", int'(if_b.count), int'(e.count));
                check("count_c", int'(if_c.count), int'(e.count));
                check("done_a",  int'(if_a.done),  int'(e.done));
                check("busy_a",  int'(if_a.busy),  int'(e.busy));
                check("done_b",  int'(if_b.done),  int'(e.done));
                check("nrst_a",  int'(if_a.nrst),  int'(e.nrst_a));
                check("nrst_b",  int'(if_b.nrst),  int'(e.nrst_b));
                check("nrst_c",  int'(if_c.nrst),  int'(e.nrst_c));
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; restart = 1'b0; lock = 1'b0;
        run(3, 1'b1, 1'b0, 1'b0);          // power-on reset
        run(4, 1'b0, 1'b0, 1'b0);          // lock low out of reset
        run(2, 1'b1, 1'b0, 1'b1);          // resynchronise both builds
        run(5, 1'b0, 1'b0, 1'b1);          // count reaches 5, nrst_a = 01
        run(1, 1'b0, 1'b1, 1'b1);          // restart pulse
        run(14, 1'b0, 1'b0, 1'b1);         // full sequence to DONE and hold
        run(20, 1'b0, 1'b1, 1'b1);         // restart held after done
        run(14, 1'b0, 1'b0, 1'b1);         // normal timing after release
        cyc(1'b0, 1'b0, 1'b0);             // lock toggling while in DONE
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        run(14, 1'b0, 1'b0, 1'b1);         // restart from lock return
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'(i % 2));
        cyc(1'b1, 1'b1, 1'b1);             // reset and restart together
        run(3, 1'b0, 1'b0, 1'b1);
        restart = 1'b0; reset = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and soft-reset sequencer that drives NUM_OUT active-low reset outputs to external devices such as the Ethernet PHY, clock chip and RF front ends. Each output releases at its own configurable count after a common start. The block succeeds the fixed two-output PHY reset counter. It adds restart on request, a lock gate and status outputs. It sits in the chip-level wrapper on the free-running internal configuration clock.

## Interface
- NUM_OUT, 2: number of reset outputs (1..16).
- CW, 22: counter width in bits.
- THRESH, {22'd2000000, 22'd1500000}: packed NUM_OUT×CW release thresholds. Slice i is THRESH[i*CW +: CW]. Output i deasserts once count > slice i.
- TERM, 22'd4194303: terminal count. The counter saturates here and done asserts.

Ports:
- clk  in  1  sequencing clock.
- reset  in  1  synchronous, active-high; restarts the whole sequence.
- restart  in  1  soft restart request, level-sensitive, synchronous.
- lock  in  1  upstream clock-locked status (used only with RESET_SEQ_LOCK_EN).
- nrst  out  NUM_OUT  active-low reset outputs, registered.
- busy  out  1  high while the sequence is not in DONE.
- done  out  1  high once the counter has reached TERM.
- count  out  CW  current counter value.

## Operation
- States: WAIT (count held at 0), COUNT (count increments by 1 each cycle), DONE (count held at TERM).
- reset=1: on the next edge, state=WAIT, count=0, nrst=all 0, done=0, busy=1.
- Reset values of outputs are exactly those above.
- WAIT→COUNT when restart=0 and the lock condition is true. The first increment happens on that same edge.
- COUNT→DONE on the edge where count becomes TERM.
- In COUNT, count increments and never wraps. Saturation at TERM is the only ceiling.
- restart=1 in any state: next edge gives WAIT, count=0, nrst=all 0, done=0.
  - While restart is held, the block stays in WAIT.
  - Release follows the normal sequence from count 0.
- Per output, registered each cycle: nrst[i] <= (count > THRESH_i) && state != WAIT.
- If THRESH_i >= TERM, output i never deasserts. This is a legal configuration: the device is held in reset permanently.
- done <= (count == TERM). busy = !done.
- Simultaneous reset and restart: reset has priority. The effect is identical.
- Outputs release in increasing-threshold order regardless of index.
- Equal thresholds release on the same edge.

## Timing
- Edge 1 is the first edge with reset=0, restart=0 and the lock condition true; count=1 after edge 1.
- Count equals k after edge k, for k ≤ TERM.
- nrst[i] rises at edge THRESH_i+2. That is one cycle after count first exceeds THRESH_i, because of the register.
- done and busy change at edge TERM+1.
- Restart or reset reasserts all nrst on the very next edge (1-cycle latency). There is no glitch: every output is driven directly from a flop.
- No combinational path exists from any input to any output.

## Configuration
- RESET_SEQ_LOCK_EN defined:
  - The lock condition is lock=1.
  - lock=0 in COUNT or DONE forces WAIT on the next edge: count=0, all nrst=0, done=0.
  - The sequence restarts from 0 once lock returns.
- RESET_SEQ_LOCK_EN undefined:
  - The lock port is present but ignored, and the lock condition is always true.
  - Only reset and restart return the block to WAIT.

## Test plan
All scenarios use CW=4, THRESH={4'd6, 4'd3}, TERM=4'd10.
- Power-on: hold reset 3 cycles, then release. Required response:
  - nrst=2'b00 and done=0 during reset.
  - nrst[0] rises at edge 5, nrst[1] at edge 8.
  - done rises at edge 11; count holds at 10 thereafter.
- Restart pulse at count=5, with nrst=2'b01 at that point. Required response:
  - Next edge gives nrst=2'b00, count=0, done=0.
  - The sequence then repeats the power-on timing measured from the restart release.
- Restart held for 20 cycles after done. Required response:
  - count stays 0, nrst=00 and busy=1 throughout.
  - Normal timing resumes after release.
- With RESET_SEQ_LOCK_EN: lock=0 out of reset leaves count=0 indefinitely. Then:
  - Raising lock starts the count at 1 on that edge.
  - Dropping lock in DONE gives nrst=00 and done=0 on the next edge.
- Without RESET_SEQ_LOCK_EN: toggling lock has no effect on count or nrst.
- Parameter edge cases:
  - THRESH slice = 4'd10 (= TERM): that output stays 0 forever while done still rises at edge 11.
  - Equal thresholds: both outputs rise on the same edge.
